// File: rtl/tpu_cmd_pkg.sv
// Shared types and constants for the TPU command dispatcher.
// Provides opcodes, FSM states, error codes and the tile-dimension decode.
package tpu_cmd_pkg;

  localparam logic [7:0] OP_GEMM_TILE = 8'h00;
  localparam logic [7:0] OP_REDUCE    = 8'h01;
  localparam logic [7:0] OP_NOP       = 8'hFF;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_OP  = 3'd1;
  localparam logic [2:0] ERR_K_ZERO  = 3'd2;
  localparam logic [2:0] ERR_DMA     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [1:0] BUF_WGT = 2'd0;
  localparam logic [1:0] BUF_ACT = 2'd1;
  localparam logic [1:0] BUF_OUT = 2'd2;

  typedef enum logic [3:0] {
    StIdle,
    StDecode,
    StLdWReq,
    StLdWWait,
    StLdAReq,
    StLdAWait,
    StCompStart,
    StCompWait,
    StStReq,
    StStWait,
    StDone,
    StCooldown,
    StError
  } disp_state_t;

  // Selector 0..15 maps to 4..64 rows/cols.
  function automatic logic [6:0] tile_dim(input logic [3:0] sel);
    return 7'({sel, 2'b00}) + 7'd4;
  endfunction

  // States whose dwell time is bounded by the phase watchdog.
  function automatic logic is_supervised(input disp_state_t s);
    return s inside {StLdWReq, StLdWWait, StLdAReq, StLdAWait,
                     StCompWait, StStReq, StStWait};
  endfunction

endpackage

// File: rtl/tpu_phase_watchdog.sv
// Reloadable down-counter bounding the dwell time of one dispatcher phase.
// expire_o is asserted in the TIMEOUT_CYCLES-th cycle after a load.
module tpu_phase_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(TIMEOUT_CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/tpu_cmd_dispatcher.sv
// Executes one tile descriptor: weight/activation prefetch, compute, evict,
// then reports a single-cycle exec_done or exec_error back to the queue.
module tpu_cmd_dispatcher
  import tpu_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LEN_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exec_valid,
  input  logic [7:0]        cmd_opcode,
  input  logic              cmd_dma_en,
  input  logic              cmd_acc81_en,
  input  logic              cmd_dataflow,
  input  logic [31:0]       cmd_out_base,
  input  logic [31:0]       cmd_act_base,
  input  logic [15:0]       cmd_wgt_base,
  input  logic [7:0]        cmd_k_tile,
  input  logic [3:0]        cmd_m_tile_sel,
  input  logic [3:0]        cmd_n_tile_sel,
  output logic              exec_done,
  output logic              exec_error,
  input  logic              abort,
  input  logic              clear_error,
  output logic              dma_req,
  output logic              dma_dir,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]  dma_len,
  output logic [1:0]        dma_buf_sel,
  input  logic              dma_ack,
  input  logic              dma_done,
  input  logic              dma_err,
  output logic              array_start,
  output logic              array_mode,
  output logic [7:0]        array_k,
  output logic [6:0]        array_m,
  output logic [6:0]        array_n,
  output logic              array_acc81,
  output logic              array_dataflow,
  input  logic              array_done,
  output logic              busy,
  output logic [2:0]        err_code,
  output logic [31:0]       last_cmd_cycles
);

  disp_state_t state_q, state_d;

  logic [7:0]        op_q;
  logic              dma_en_q, acc_q, df_q, mode_q;
  logic [31:0]       out_base_q, act_base_q;
  logic [15:0]       wgt_base_q;
  logic [7:0]        k_q;
  logic [6:0]        m_q, n_q;
  logic              latch;

  logic              dma_req_q, dma_req_d, dma_dir_q, dma_dir_d;
  logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
  logic [LEN_W-1:0]  dma_len_q, dma_len_d;
  logic [1:0]        dma_buf_q, dma_buf_d;
  logic              array_start_q, array_start_d;
  logic              exec_done_q, exec_done_d, exec_error_q, exec_error_d;
  logic              busy_q, busy_d;
  logic [2:0]        err_q, err_d;
  logic [31:0]       cyc_q, cyc_d, last_q, last_d;

  logic [14:0]       len_wgt, len_act, len_out;
  logic              wd_load, wd_expire;

  assign len_wgt = 15'(k_q) * 15'(n_q);
  assign len_act = 15'(m_q) * 15'(k_q);
  assign len_out = 15'(m_q) * 15'(n_q);

  assign wd_load = (state_d != state_q) && is_supervised(state_d);

  tpu_phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (wd_load),
    .en_i    (is_supervised(state_q)),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    last_d     = last_q;
    latch      = 1'b0;
    cyc_d      = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
    dma_dir_d  = dma_dir_q;
    dma_addr_d = dma_addr_q;
    dma_len_d  = dma_len_q;
    dma_buf_d  = dma_buf_q;

    unique case (state_q)
      StIdle: begin
        if (exec_valid) begin
          state_d = StDecode;
          latch   = 1'b1;
        end
      end
      StDecode: begin
        cyc_d = 32'd1;
        if (op_q == OP_NOP) begin
          state_d = StDone;
        end else if ((op_q != OP_GEMM_TILE) && (op_q != OP_REDUCE)) begin
          state_d = StError;
          err_d   = ERR_BAD_OP;
        end else if (k_q == 8'd0) begin
          state_d = StError;
          err_d   = ERR_K_ZERO;
        end else begin
          state_d = dma_en_q ? StLdWReq : StCompStart;
        end
      end
      StLdWReq, StLdAReq, StStReq: begin
        if (dma_err) begin
          state_d = StError;
          err_d   = ERR_DMA;
        end else if (dma_ack) begin
          state_d = (state_q == StLdWReq) ? StLdWWait :
                    (state_q == StLdAReq) ? StLdAWait : StStWait;
        end else if (wd_expire) begin
          state_d = StError;
          err_d   = ERR_TIMEOUT;
        end
      end
      StLdWWait, StLdAWait, StStWait: begin
        // An error reported alongside completion still fails the command.
        if (dma_err) begin
          state_d = StError;
          err_d   = ERR_DMA;
        end else if (dma_done) begin
          state_d = (state_q == StLdWWait) ? StLdAReq :
                    (state_q == StLdAWait) ? StCompStart : StDone;
        end else if (wd_expire) begin
          state_d = StError;
          err_d   = ERR_TIMEOUT;
        end
      end
      StCompStart: state_d = StCompWait;
      StCompWait: begin
        if (array_done) begin
          state_d = dma_en_q ? StStReq : StDone;
        end else if (wd_expire) begin
          state_d = StError;
          err_d   = ERR_TIMEOUT;
        end
      end
      StDone: begin
        last_d  = cyc_q;
        state_d = StCooldown;
      end
      StCooldown: state_d = StIdle;
      StError: begin
        if (clear_error) begin
          state_d = StIdle;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      err_d   = ERR_NONE;
      latch   = 1'b0;
    end

    unique case (state_d)
      StLdWReq: begin
        dma_dir_d  = 1'b0;
        dma_addr_d = ADDR_W'(wgt_base_q);
        dma_len_d  = LEN_W'(len_wgt);
        dma_buf_d  = BUF_WGT;
      end
      StLdAReq: begin
        dma_dir_d  = 1'b0;
        dma_addr_d = ADDR_W'(act_base_q);
        dma_len_d  = LEN_W'(len_act);
        dma_buf_d  = BUF_ACT;
      end
      StStReq: begin
        dma_dir_d  = 1'b1;
        dma_addr_d = ADDR_W'(out_base_q);
        dma_len_d  = LEN_W'(len_out);
        dma_buf_d  = BUF_OUT;
      end
      default: ;
    endcase

    // Outputs are registered images of the next state.
    dma_req_d     = state_d inside {StLdWReq, StLdAReq, StStReq};
    array_start_d = (state_d == StCompStart);
    exec_done_d   = (state_d == StDone);
    exec_error_d  = (state_d == StError) && (state_q != StError);
    busy_d        = !(state_d inside {StIdle, StError});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_q          <= 8'd0;
      dma_en_q      <= 1'b0;
      acc_q         <= 1'b0;
      df_q          <= 1'b0;
      mode_q        <= 1'b0;
      out_base_q    <= 32'd0;
      act_base_q    <= 32'd0;
      wgt_base_q    <= 16'd0;
      k_q           <= 8'd0;
      m_q           <= 7'd0;
      n_q           <= 7'd0;
      dma_req_q     <= 1'b0;
      dma_dir_q     <= 1'b0;
      dma_addr_q    <= '0;
      dma_len_q     <= '0;
      dma_buf_q     <= 2'd0;
      array_start_q <= 1'b0;
      exec_done_q   <= 1'b0;
      exec_error_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= ERR_NONE;
      cyc_q         <= 32'd0;
      last_q        <= 32'd0;
    end else begin
      state_q       <= state_d;
      if (latch) begin
        op_q       <= cmd_opcode;
        dma_en_q   <= cmd_dma_en;
        acc_q      <= cmd_acc81_en;
        df_q       <= cmd_dataflow;
        mode_q     <= (cmd_opcode == OP_REDUCE);
        out_base_q <= cmd_out_base;
        act_base_q <= cmd_act_base;
        wgt_base_q <= cmd_wgt_base;
        k_q        <= cmd_k_tile;
        m_q        <= tile_dim(cmd_m_tile_sel);
        n_q        <= tile_dim(cmd_n_tile_sel);
      end
      dma_req_q     <= dma_req_d;
      dma_dir_q     <= dma_dir_d;
      dma_addr_q    <= dma_addr_d;
      dma_len_q     <= dma_len_d;
      dma_buf_q     <= dma_buf_d;
      array_start_q <= array_start_d;
      exec_done_q   <= exec_done_d;
      exec_error_q  <= exec_error_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      cyc_q         <= cyc_d;
      last_q        <= last_d;
    end
  end

  assign exec_done       = exec_done_q;
  assign exec_error      = exec_error_q;
  assign dma_req         = dma_req_q;
  assign dma_dir         = dma_dir_q;
  assign dma_addr        = dma_addr_q;
  assign dma_len         = dma_len_q;
  assign dma_buf_sel     = dma_buf_q;
  assign array_start     = array_start_q;
  assign array_mode      = mode_q;
  assign array_k         = k_q;
  assign array_m         = m_q;
  assign array_n         = n_q;
  assign array_acc81     = acc_q;
  assign array_dataflow  = df_q;
  assign busy            = busy_q;
  assign err_code        = err_q;
  assign last_cmd_cycles = last_q;

endmodule

// File: tb/tb_tpu_cmd_dispatcher.sv
// Directed bench for tpu_cmd_dispatcher with DMA and completion scoreboards.
module tb_tpu_cmd_dispatcher;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exec_valid = 1'b0;
  logic [7:0]  cmd_opcode = 8'd0;
  logic        cmd_dma_en = 1'b0, cmd_acc81_en = 1'b0, cmd_dataflow = 1'b0;
  logic [31:0] cmd_out_base = 32'd0, cmd_act_base = 32'd0;
  logic [15:0] cmd_wgt_base = 16'd0;
  logic [7:0]  cmd_k_tile = 8'd0;
  logic [3:0]  cmd_m_tile_sel = 4'd0, cmd_n_tile_sel = 4'd0;
  logic        abort = 1'b0, clear_error = 1'b0;
  logic        dma_ack = 1'b0, dma_done = 1'b0, dma_err = 1'b0, array_done = 1'b0;
  logic        exec_done, exec_error, dma_req, dma_dir, array_start, array_mode;
  logic [31:0] dma_addr;
  logic [15:0] dma_len;
  logic [1:0]  dma_buf_sel;
  logic [7:0]  array_k;
  logic [6:0]  array_m, array_n;
  logic        array_acc81, array_dataflow, busy;
  logic [2:0]  err_code;
  logic [31:0] last_cmd_cycles;

  always #5 clk = ~clk;

  tpu_cmd_dispatcher #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_W        (32),
    .LEN_W         (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exec_valid     (exec_valid),
    .cmd_opcode     (cmd_opcode),
    .cmd_dma_en     (cmd_dma_en),
    .cmd_acc81_en   (cmd_acc81_en),
    .cmd_dataflow   (cmd_dataflow),
    .cmd_out_base   (cmd_out_base),
    .cmd_act_base   (cmd_act_base),
    .cmd_wgt_base   (cmd_wgt_base),
    .cmd_k_tile     (cmd_k_tile),
    .cmd_m_tile_sel (cmd_m_tile_sel),
    .cmd_n_tile_sel (cmd_n_tile_sel),
    .exec_done      (exec_done),
    .exec_error     (exec_error),
    .abort          (abort),
    .clear_error    (clear_error),
    .dma_req        (dma_req),
    .dma_dir        (dma_dir),
    .dma_addr       (dma_addr),
    .dma_len        (dma_len),
    .dma_buf_sel    (dma_buf_sel),
    .dma_ack        (dma_ack),
    .dma_done       (dma_done),
    .dma_err        (dma_err),
    .array_start    (array_start),
    .array_mode     (array_mode),
    .array_k        (array_k),
    .array_m        (array_m),
    .array_n        (array_n),
    .array_acc81    (array_acc81),
    .array_dataflow (array_dataflow),
    .array_done     (array_done),
    .busy           (busy),
    .err_code       (err_code),
    .last_cmd_cycles(last_cmd_cycles)
  );

  typedef struct {
    logic        dir;
    logic [31:0] addr;
    logic [15:0] len;
    logic [1:0]  bsel;
  } dma_exp_t;

  typedef struct {
    logic       is_err;
    logic [2:0] code;
  } res_exp_t;

  dma_exp_t dma_q[$];
  res_exp_t res_q[$];

  int total = 0, bad = 0, cyc = 0;
  int done_seen = 0, err_seen = 0, start_seen = 0, req_seen = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic miss(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=none expected=event", tag);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exec_done) done_seen++;
      if (exec_error) err_seen++;
      if (array_start) start_seen++;
      if (dma_req && !req_prev) req_seen++;
      if (exec_done || exec_error) chk("done_err_exclusive", exec_done & exec_error, 0);
    end
    req_prev = dma_req;
  end

  function automatic int dim(input int sel);
    return 4 * (sel + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_dma(input logic dir, input logic [31:0] addr, input int len,
                          input logic [1:0] bsel);
    dma_exp_t e;
    e.dir = dir; e.addr = addr; e.len = 16'(len); e.bsel = bsel;
    dma_q.push_back(e);
  endtask

  task automatic push_res(input logic is_err, input logic [2:0] code);
    res_exp_t r;
    r.is_err = is_err; r.code = code;
    res_q.push_back(r);
  endtask

  task automatic issue(input logic [7:0] op, input logic den, input logic [7:0] k,
                       input logic [3:0] ms, input logic [3:0] ns, input logic [31:0] ob,
                       input logic [31:0] ab, input logic [15:0] wb, input logic acc,
                       input logic df, input logic hold);
    cmd_opcode = op; cmd_dma_en = den; cmd_k_tile = k; cmd_m_tile_sel = ms;
    cmd_n_tile_sel = ns; cmd_out_base = ob; cmd_act_base = ab; cmd_wgt_base = wb;
    cmd_acc81_en = acc; cmd_dataflow = df;
    exec_valid = 1'b1;
    step();
    exec_valid = hold;
  endtask

  task automatic take_req(input string tag);
    dma_exp_t e;
    int n = 0;
    while (!dma_req && n < 50) begin step(); n++; end
    if (!dma_req) miss({tag, "_req"});
    if (dma_q.size() == 0) begin
      miss({tag, "_dma_queue"});
    end else begin
      e = dma_q.pop_front();
      chk({tag, "_dir"}, dma_dir, e.dir);
      chk({tag, "_addr"}, dma_addr, e.addr);
      chk({tag, "_len"}, dma_len, e.len);
      chk({tag, "_buf"}, dma_buf_sel, e.bsel);
      step();
      chk({tag, "_req_held"}, dma_req, 1);
      chk({tag, "_addr_stable"}, dma_addr, e.addr);
    end
    dma_ack = 1'b1;
    step();
    dma_ack = 1'b0;
    chk({tag, "_req_drop"}, dma_req, 0);
  endtask

  task automatic pulse_dma_done();
    dma_done = 1'b1; step(); dma_done = 1'b0;
  endtask

  task automatic pulse_array_done();
    array_done = 1'b1; step(); array_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!array_start && n < 50) begin step(); n++; end
    if (!array_start) miss({tag, "_array_start"});
  endtask

  task automatic wait_result(input string tag, output int t);
    res_exp_t r;
    int n = 0;
    while (!(exec_done || exec_error) && n < 300) begin step(); n++; end
    t = cyc;
    if (!(exec_done || exec_error)) begin
      miss({tag, "_completion"});
    end else if (res_q.size() == 0) begin
      miss({tag, "_res_queue"});
    end else begin
      r = res_q.pop_front();
      chk({tag, "_exec_error"}, exec_error, r.is_err);
      chk({tag, "_exec_done"}, exec_done, !r.is_err);
      chk({tag, "_err_code"}, err_code, r.code);
    end
  endtask

  task automatic clear_err();
    clear_error = 1'b1; step(); clear_error = 1'b0;
  endtask

  initial begin
    int t0, tdone, n, d, e, s, r;

    repeat (3) step();
    chk("rst_dma_req", dma_req, 0);
    chk("rst_exec_done", exec_done, 0);
    chk("rst_exec_error", exec_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_last_cycles", last_cmd_cycles, 0);
    chk("rst_dma_addr", dma_addr, 0);
    chk("rst_array_m", array_m, 0);
    rst_n = 1'b1;
    step();

    // GEMM with full prefetch/compute/evict
    push_dma(1'b0, 32'h0000_1234, 16 * dim(3), 2'd0);
    push_dma(1'b0, 32'h4000_0200, dim(1) * 16, 2'd1);
    push_dma(1'b1, 32'h8000_1000, dim(1) * dim(3), 2'd2);
    push_res(1'b0, 3'd0);
    d = done_seen;
    issue(8'h00, 1'b1, 8'd16, 4'd1, 4'd3, 32'h8000_1000, 32'h4000_0200, 16'h1234,
          1'b1, 1'b1, 1'b0);
    t0 = cyc;
    chk("t1_busy", busy, 1);
    take_req("t1_w"); repeat (3) step(); pulse_dma_done();
    take_req("t1_a"); step(); pulse_dma_done();
    wait_start("t1");
    chk("t1_array_k", array_k, 16);
    chk("t1_array_m", array_m, 8);
    chk("t1_array_n", array_n, 16);
    chk("t1_array_mode", array_mode, 0);
    chk("t1_array_acc81", array_acc81, 1);
    chk("t1_array_df", array_dataflow, 1);
    step();
    chk("t1_start_one_cycle", array_start, 0);
    repeat (3) step();
    pulse_array_done();
    take_req("t1_s"); step(); pulse_dma_done();
    wait_result("t1", tdone);
    chk("t1_cfg_hold_n", array_n, 16);
    step();
    chk("t1_cooldown_busy", busy, 1);
    chk("t1_single_done", exec_done, 0);
    chk("t1_last_cycles", last_cmd_cycles, tdone - t0);
    step();
    chk("t1_idle", busy, 0);
    chk("t1_done_count", done_seen, d + 1);

    // NOP with exec_valid held through cooldown
    r = req_seen; s = start_seen;
    push_res(1'b0, 3'd0);
    push_res(1'b0, 3'd0);
    issue(8'hFF, 1'b0, 8'd0, 4'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    t0 = cyc;
    chk("t2_decode_quiet", exec_done, 0);
    step();
    wait_result("t2a", tdone);
    chk("t2_latency", tdone - t0, 1);
    step();
    chk("t2_cooldown_busy", busy, 1);
    chk("t2_last_cycles", last_cmd_cycles, 1);
    step();
    chk("t2_idle_after_cooldown", busy, 0);
    step();
    chk("t2_second_accept", busy, 1);
    exec_valid = 1'b0;
    wait_result("t2b", tdone);
    step(); step();
    chk("t2_no_dma", req_seen, r);
    chk("t2_no_start", start_seen, s);

    // Illegal opcode
    push_res(1'b1, 3'd1);
    issue(8'h07, 1'b1, 8'd4, 4'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    wait_result("t3", tdone);
    step();
    chk("t3_error_single", exec_error, 0);
    chk("t3_error_not_busy", busy, 0);
    repeat (3) step();
    chk("t3_err_sticky", err_code, 1);
    clear_err();
    chk("t3_err_cleared", err_code, 0);
    chk("t3_idle", busy, 0);

    // K = 0 is rejected before any DMA
    r = req_seen;
    push_res(1'b1, 3'd2);
    issue(8'h00, 1'b1, 8'd0, 4'd0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    wait_result("t3b", tdone);
    chk("t3b_no_dma", req_seen, r);
    clear_err();

    // dma_err beats a simultaneous dma_done in LD_A_WAIT; widest N
    push_dma(1'b0, 32'h0000_BEEF, 2 * dim(15), 2'd0);
    push_dma(1'b0, 32'h1000_0040, dim(0) * 2, 2'd1);
    push_res(1'b1, 3'd3);
    s = start_seen;
    issue(8'h00, 1'b1, 8'd2, 4'd0, 4'd15, 32'h2000_0000, 32'h1000_0040, 16'hBEEF,
          1'b0, 1'b0, 1'b0);
    take_req("t4_w"); step(); pulse_dma_done();
    take_req("t4_a"); step();
    dma_done = 1'b1; dma_err = 1'b1;
    step();
    dma_done = 1'b0; dma_err = 1'b0;
    wait_result("t4", tdone);
    chk("t4_no_compute", start_seen, s);
    clear_err();

    // Compute-phase timeout, REDUCE, tallest M, no DMA
    push_res(1'b1, 3'd4);
    issue(8'h01, 1'b0, 8'd5, 4'd15, 4'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    wait_start("t5");
    chk("t5_array_m", array_m, 64);
    chk("t5_array_n", array_n, 4);
    chk("t5_array_k", array_k, 5);
    chk("t5_array_mode", array_mode, 1);
    chk("t5_array_df", array_dataflow, 0);
    n = 0;
    while (!exec_error && n < int'(TO) + 20) begin step(); n++; end
    chk("t5_timeout_cycle", n, TO + 1);
    wait_result("t5", tdone);
    clear_err();

    // Abort during ST_WAIT, then a stale dma_done
    push_dma(1'b0, 32'h0000_0100, 1 * dim(0), 2'd0);
    push_dma(1'b0, 32'h3000_0000, dim(0) * 1, 2'd1);
    push_dma(1'b1, 32'h5000_0000, dim(0) * dim(0), 2'd2);
    d = done_seen; e = err_seen;
    issue(8'h00, 1'b1, 8'd1, 4'd0, 4'd0, 32'h5000_0000, 32'h3000_0000, 16'h0100,
          1'b0, 1'b0, 1'b0);
    take_req("t6_w"); step(); pulse_dma_done();
    take_req("t6_a"); step(); pulse_dma_done();
    wait_start("t6");
    step(); step();
    pulse_array_done();
    take_req("t6_s"); step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_req", dma_req, 0);
    chk("t6_abort_err", err_code, 0);
    pulse_dma_done();
    repeat (3) step();
    chk("t6_stale_done_busy", busy, 0);
    chk("t6_no_exec_done", done_seen, d);
    chk("t6_no_exec_error", err_seen, e);

    // Normal command after abort
    push_res(1'b0, 3'd0);
    issue(8'h00, 1'b0, 8'd3, 4'd2, 4'd2, 32'd0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b0);
    t0 = cyc;
    wait_start("t7");
    chk("t7_array_m", array_m, 12);
    step(); step();
    pulse_array_done();
    wait_result("t7", tdone);
    step();
    chk("t7_last_cycles", last_cmd_cycles, tdone - t0);

    chk("dma_queue_empty", dma_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_cmd_dispatcher.md
Name: tpu_cmd_dispatcher

Overview:
Sequences one tile descriptor at a time from the TPU command queue: weight/activation DMA prefetch, systolic-array compute, output evict. It then returns a single-cycle exec_done or exec_error to the queue. It sits between the queue's parsed-field outputs and the DMA engine plus array controller, and owns per-phase timeout supervision.

Parameters:
TIMEOUT_CYCLES, 65535, max cycles any single wait phase may last before an error is declared.
ADDR_W, 32, DMA address width.
LEN_W, 16, DMA transfer length width (words).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exec_valid  in  1  queue head descriptor valid
cmd_opcode  in  8  0x00 GEMM_TILE, 0x01 REDUCE, 0xFF NOP
cmd_dma_en  in  1  perform prefetch/evict DMA
cmd_acc81_en  in  1  81-trit accumulator path
cmd_dataflow  in  1  0 output-stationary, 1 weight-stationary
cmd_out_base  in  32  output base address
cmd_act_base  in  32  activation base address
cmd_wgt_base  in  16  weight base address
cmd_k_tile  in  8  K dimension
cmd_m_tile_sel  in  4  tile height selector
cmd_n_tile_sel  in  4  tile width selector
exec_done  out  1  one-cycle pulse: command completed
exec_error  out  1  one-cycle pulse: command failed
abort  in  1  synchronous abort (tied to queue flush)
clear_error  in  1  leave ERROR state
dma_req  out  1  DMA request, held until dma_ack
dma_dir  out  1  0 load (mem->buffer), 1 store
dma_addr  out  ADDR_W  transfer base address
dma_len  out  LEN_W  transfer length in words
dma_buf_sel  out  2  0 weight buf, 1 act buf, 2 out buf
dma_ack  in  1  request accepted
dma_done  in  1  transfer complete pulse
dma_err  in  1  transfer error pulse
array_start  out  1  one-cycle compute start pulse
array_mode  out  1  0 GEMM, 1 REDUCE
array_k  out  8  latched K
array_m  out  7  latched M rows
array_n  out  7  latched N cols
array_acc81  out  1  latched acc81_en
array_dataflow  out  1  latched dataflow
array_done  in  1  compute complete pulse
busy  out  1  state not IDLE/ERROR
err_code  out  3  0 none, 1 bad opcode, 2 K=0, 3 DMA error, 4 timeout
last_cmd_cycles  out  32  cycles from DECODE to DONE of last successful command

Behaviour:
- Reset: all outputs 0, state IDLE, err_code 0, last_cmd_cycles 0.
- Dimensions: M = 4*(m_sel+1), N = 4*(n_sel+1), range 4..64. Weight len = K*N, act len = M*K, out len = M*N, all zero-extended to LEN_W. Max 16320 fits 16 bits. wgt_base zero-extended to ADDR_W.
- States: IDLE, DECODE, LD_W_REQ, LD_W_WAIT, LD_A_REQ, LD_A_WAIT, COMP_START, COMP_WAIT, ST_REQ, ST_WAIT, DONE, COOLDOWN, ERROR.
- IDLE: exec_valid=1 -> DECODE.
- DECODE: latch all cmd fields into working registers. Clear cycle counter.
  - Opcode not in {00,01,FF} -> ERROR, err 1.
  - NOP -> DONE.
  - K=0 (GEMM/REDUCE) -> ERROR, err 2.
  - dma_en=1 -> LD_W_REQ; otherwise -> COMP_START.
- *_REQ: dma_req=1 with addr/len/dir/buf_sel stable; dma_ack -> matching *_WAIT (req drops the same edge).
- *_WAIT: dma_done -> next phase. Sequence is LD_W -> LD_A -> COMP_START; ST_WAIT -> DONE.
- COMP_START: array_start pulse for one cycle, -> COMP_WAIT. array_* config outputs stay stable from DECODE until the DONE exit.
- COMP_WAIT: array_done -> ST_REQ if dma_en, otherwise DONE.
- Watchdog: phase counter reloads on every entry to a REQ/WAIT state. Reaching TIMEOUT_CYCLES while in that state -> ERROR, err 4.
- dma_err in any REQ/WAIT state -> ERROR, err 3. dma_err wins over a same-cycle dma_done.
- DONE: exec_done=1 for one cycle, update last_cmd_cycles, -> COOLDOWN.
- COOLDOWN: ignore exec_valid for one cycle so the queue can advance its pointer, -> IDLE.
- ERROR entry: exec_error=1 for one cycle. Hold state; clear_error -> IDLE and err_code 0. err_code is sticky until then.
- abort (any state): next cycle IDLE, all req/start outputs 0, no exec_done/exec_error pulse. Stale dma_done/array_done arriving in IDLE is ignored. err_code is cleared.
- exec_done and exec_error are never asserted in the same cycle.
- last_cmd_cycles saturates at 2^32-1.

Decomposition:
- Package tpu_cmd_pkg:
  - opcode localparams (OP_GEMM_TILE, OP_REDUCE, OP_NOP).
  - disp_state_t enum.
  - err_code constants.
  - tile_dim(sel) function.
- One sub-module, tpu_phase_watchdog: reloadable down-counter with an expire pulse. It is instantiated once.

Test Plan:
- GEMM, dma_en=1, K=16, m_sel=1, n_sel=3 -> loads len 256 (W), 128 (A), array_m=8/n=16, store len 128 at out_base. Exactly one exec_done, then COOLDOWN.
- NOP with exec_valid held -> exec_done 2 cycles after IDLE exit. No dma_req or array_start. Next command is sampled only after COOLDOWN.
- Opcode 0x07 -> exec_error pulse, err_code 1, stays ERROR. clear_error -> IDLE, err_code 0.
- dma_done and dma_err in the same cycle in LD_A_WAIT -> ERROR err 3. Array never started.
- TIMEOUT_CYCLES=100, array_done withheld -> exec_error at cycle 100 of COMP_WAIT, err 4.
- abort during ST_WAIT, then late dma_done -> IDLE, no exec_done, busy=0. Next descriptor executes normally.
